// File: rtl/conv2_row_feeder.sv
// Packs four channels of pooled pixels into full rows and hands each row to the conv layer-2 row buffer.
// Optional build macro CONV2_FEED_RELU_EN clamps pixels with bit 7 set to zero before storing them.
module conv2_row_feeder #(
   parameter int ROW_PIX = 12,
   parameter int ROWS    = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   conv_busy,
   input  logic                   pix_valid,
   output logic                   pix_ready,
   input  logic [7:0]             pix_0,
   input  logic [7:0]             pix_1,
   input  logic [7:0]             pix_2,
   input  logic [7:0]             pix_3,
   output logic                   din_valid,
   output logic [8*ROW_PIX-1:0]   data_in_0,
   output logic [8*ROW_PIX-1:0]   data_in_1,
   output logic [8*ROW_PIX-1:0]   data_in_2,
   output logic [8*ROW_PIX-1:0]   data_in_3,
   output logic                   pool_end,
   output logic                   frame_busy
);

   localparam int              W        = 8 * ROW_PIX;
   localparam int              PW       = (ROW_PIX > 1) ? $clog2(ROW_PIX) : 1;
   localparam logic [PW-1:0]   PIX_LAST = PW'(ROW_PIX - 1);
   localparam logic [9:0]      ROW_LAST = 10'(ROWS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_EMIT,
      ST_END
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
   logic [9:0]      row_cnt_q, row_cnt_d;
   logic [W-1:0]    fill_q [4];
   logic [W-1:0]    fill_d [4];
   logic [W-1:0]    data_q [4];
   logic [W-1:0]    data_d [4];
   logic [7:0]      pix_in [4];
   logic [7:0]      pix_st [4];

   always_comb begin
      pix_in = '{pix_0, pix_1, pix_2, pix_3};
      for (int c = 0; c < 4; c++) begin
`ifdef CONV2_FEED_RELU_EN
         pix_st[c] = pix_in[c][7] ? 8'h00 : pix_in[c];
`else
         pix_st[c] = pix_in[c];
`endif
      end
   end

   // NOTE: every signal driven here gets its default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      pix_cnt_d = pix_cnt_q;
      row_cnt_d = row_cnt_q;
      fill_d    = fill_q;
      data_d    = data_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !conv_busy) state_d = ST_FILL;
         end
         ST_FILL: begin
            if (pix_valid) begin
               for (int c = 0; c < 4; c++) begin
                  for (int k = 0; k < ROW_PIX; k++) begin
                     if (pix_cnt_q == PW'(k)) fill_d[c][W-1-8*k -: 8] = pix_st[c];
                  end
               end
               // The finished row moves to the output registers only now, so data_in holds between strobes.
               if (pix_cnt_q == PIX_LAST) begin
                  state_d = ST_EMIT;
                  data_d  = fill_d;
               end else begin
                  pix_cnt_d = pix_cnt_q + 1'b1;
               end
            end
         end
         ST_EMIT: begin
            pix_cnt_d = '0;
            if (row_cnt_q == ROW_LAST) begin
               state_d = ST_END;
            end else begin
               state_d   = ST_FILL;
               row_cnt_d = row_cnt_q + 1'b1;
            end
         end
         ST_END: begin
            row_cnt_d = '0;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pix_cnt_q <= '0;
         row_cnt_q <= '0;
         // NOTE: the row arrays are small registers, not RAM, so they are cleared by reset like any flop.
         for (int c = 0; c < 4; c++) begin
            fill_q[c] <= '0;
            data_q[c] <= '0;
         end
      end else begin
         state_q   <= state_d;
         pix_cnt_q <= pix_cnt_d;
         row_cnt_q <= row_cnt_d;
         fill_q    <= fill_d;
         data_q    <= data_d;
      end
   end

   assign pix_ready  = (state_q == ST_FILL);
   assign din_valid  = (state_q == ST_EMIT);
   assign pool_end   = (state_q == ST_END);
   assign frame_busy = (state_q != ST_IDLE);
   assign data_in_0  = data_q[0];
   assign data_in_1  = data_q[1];
   assign data_in_2  = data_q[2];
   assign data_in_3  = data_q[3];

endmodule

// File: tb/tb_conv2_row_feeder.sv
// Bench for conv2_row_feeder: random and patterned frames checked against a row-packing model.
module tb_conv2_row_feeder;

   localparam int ROW_PIX = 12;
   localparam int ROWS    = 16;
   localparam int W       = 8 * ROW_PIX;

   typedef logic [3:0][W-1:0] row_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic          conv_busy = 1'b0;
   logic          pix_valid = 1'b0;
   logic [7:0]    p_in [4];
   logic          pix_ready, din_valid, pool_end, frame_busy;
   logic [W-1:0]  data_in_0, data_in_1, data_in_2, data_in_3;

   int   n_vec = 0;
   int   n_err = 0;
   row_t exp_q [$];
   row_t obs_rows [$];
   row_t ref_rows [$];

   conv2_row_feeder #(.ROW_PIX(ROW_PIX), .ROWS(ROWS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .conv_busy  (conv_busy),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_0      (p_in[0]),
      .pix_1      (p_in[1]),
      .pix_2      (p_in[2]),
      .pix_3      (p_in[3]),
      .din_valid  (din_valid),
      .data_in_0  (data_in_0),
      .data_in_1  (data_in_1),
      .data_in_2  (data_in_2),
      .data_in_3  (data_in_3),
      .pool_end   (pool_end),
      .frame_busy (frame_busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] stored(input logic [7:0] p);
`ifdef CONV2_FEED_RELU_EN
      return p[7] ? 8'h00 : p;
`else
      return p;
`endif
   endfunction

   task automatic check_all_zero(input string tag);
      row_t obs;
      obs = {data_in_3, data_in_2, data_in_1, data_in_0};
      n_vec++;
      if ({din_valid, pool_end, pix_ready, frame_busy} !== 4'b0000) begin
         n_err++;
         $display("FAIL %s_ctrl got %b want 0000", tag, {din_valid, pool_end, pix_ready, frame_busy});
      end
      n_vec++;
      if (obs !== '0) begin
         n_err++;
         $display("FAIL %s_data got %h want 0", tag, obs);
      end
   endtask

   // Runs one frame. mode 0: pix_valid held high, 1: toggled, 2: random with stray start/conv_busy.
   task automatic run_frame(input int mode, input bit pattern, input int abort_rows, input bit force85,
                            output int end_cyc, output int first_dv_cyc, output int rows_seen);
      row_t acc, last, obs, e;
      bit   have_last, done, tog;
      int   cyc, k, row, abort_at;
      exp_q.delete();
      obs_rows.delete();
      acc = '0; last = '0; have_last = 0; done = 0; tog = 0;
      k = 0; row = 0; abort_at = -1;
      end_cyc = -1; first_dv_cyc = -1; rows_seen = 0;
      @(negedge clk);
      start = 1'b1; conv_busy = 1'b0; pix_valid = 1'b0;
      cyc = 0;
      while (!done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         obs = {data_in_3, data_in_2, data_in_1, data_in_0};
         n_vec++;
         if (frame_busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_in_frame cyc%0d got %b want 1", cyc, frame_busy);
         end
         n_vec++;
         if ((din_valid && pool_end) || ((din_valid || pool_end) && pix_ready)) begin
            n_err++;
            $display("FAIL strobe_excl cyc%0d got dv=%b pe=%b rdy=%b want exclusive", cyc, din_valid, pool_end, pix_ready);
         end
         if (din_valid) begin
            if (first_dv_cyc < 0) first_dv_cyc = cyc;
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL row_extra cyc%0d got strobe want none", cyc);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin
                  n_err++;
                  $display("FAIL row%0d got %h want %h", rows_seen, obs, e);
               end
            end
            obs_rows.push_back(obs);
            last = obs; have_last = 1; rows_seen++;
            if (abort_rows > 0 && rows_seen == abort_rows && abort_at < 0) abort_at = cyc + 3;
         end else if (have_last) begin
            n_vec++;
            if (obs !== last) begin
               n_err++;
               $display("FAIL row_hold cyc%0d got %h want %h", cyc, obs, last);
            end
         end
         if (pool_end) begin
            end_cyc = cyc;
            done = 1;
         end else if (cyc == abort_at) begin
            rst_n = 1'b0;
            #1;
            check_all_zero("abort");
            repeat (3) begin
               @(negedge clk);
               n_vec++;
               if (pool_end !== 1'b0) begin
                  n_err++;
                  $display("FAIL abort_pool_end got %b want 0", pool_end);
               end
            end
            start = 1'b0; pix_valid = 1'b0; conv_busy = 1'b0;
            rst_n = 1'b1;
            repeat (4) begin
               @(negedge clk);
               n_vec++;
               if ({frame_busy, pool_end} !== 2'b00) begin
                  n_err++;
                  $display("FAIL abort_idle got %b want 00", {frame_busy, pool_end});
               end
            end
            done = 1;
         end else begin
            tog = !tog;
            start     = (mode == 2) ? ($urandom_range(0, 15) == 0) : 1'b0;
            conv_busy = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            case (mode)
               0:       pix_valid = 1'b1;
               1:       pix_valid = tog;
               default: pix_valid = ($urandom_range(0, 2) != 0);
            endcase
            for (int c = 0; c < 4; c++) begin
               p_in[c] = (pattern && pix_ready) ? 8'(k + 16 * row + 64 * c) : 8'($urandom);
            end
            if (force85 && pix_ready && row == 0 && k == 0) p_in[0] = 8'h85;
            if (pix_ready && pix_valid) begin
               for (int c = 0; c < 4; c++) begin
                  acc[c] = acc[c] | (W'(stored(p_in[c])) << (8 * (ROW_PIX - 1 - k)));
               end
               k++;
               if (k == ROW_PIX) begin
                  exp_q.push_back(acc);
                  acc = '0; k = 0; row++;
               end
            end
         end
      end
      start = 1'b0; pix_valid = 1'b0; conv_busy = 1'b0;
      if (!done) begin
         n_vec++; n_err++;
         $display("FAIL frame_timeout got no pool_end want pool_end within 2000 cycles");
      end
   endtask

   task automatic check_int(input string tag, input int got, input int want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got %0d want %0d", tag, got, want);
      end
   endtask

   task automatic test_reset();
      for (int c = 0; c < 4; c++) p_in[c] = 8'h00;
      #2 rst_n = 1'b0;
      #1 check_all_zero("reset_async");
      repeat (2) @(negedge clk);
      check_all_zero("reset_hold");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset_idle");
   endtask

   task automatic test_full_frame();
      int   end_cyc, dv_cyc, rows;
      row_t r0;
      logic [W-1:0] row0_ref;
      run_frame(0, 1'b1, 0, 1'b0, end_cyc, dv_cyc, rows);
      check_int("full_rows", rows, ROWS);
      check_int("full_first_dv", dv_cyc, ROW_PIX + 1);
      check_int("full_length", end_cyc + 1, 1 + ROWS * (ROW_PIX + 1) + 1);
      row0_ref = 96'h000102030405060708090A0B;
      n_vec++;
      if (obs_rows.size() == 0) begin
         n_err++;
         $display("FAIL full_row0 got no rows want one");
      end else begin
         r0 = obs_rows[0];
         if (r0[0] !== row0_ref) begin
            n_err++;
            $display("FAIL full_row0 got %h want %h", r0[0], row0_ref);
         end
      end
      ref_rows = obs_rows;
      @(negedge clk);
      n_vec++;
      if (frame_busy !== 1'b0) begin
         n_err++;
         $display("FAIL full_idle got %b want 0", frame_busy);
      end
   endtask

   task automatic test_throttled();
      int end_cyc, dv_cyc, rows;
      run_frame(1, 1'b1, 0, 1'b0, end_cyc, dv_cyc, rows);
      check_int("thr_rows", rows, ROWS);
      n_vec++;
      if (end_cyc <= 1 + ROWS * (ROW_PIX + 1)) begin
         n_err++;
         $display("FAIL thr_stall got %0d want > %0d", end_cyc, 1 + ROWS * (ROW_PIX + 1));
      end
      for (int i = 0; i < ROWS && i < obs_rows.size() && i < ref_rows.size(); i++) begin
         n_vec++;
         if (obs_rows[i] !== ref_rows[i]) begin
            n_err++;
            $display("FAIL thr_row%0d got %h want %h", i, obs_rows[i], ref_rows[i]);
         end
      end
   endtask

   task automatic test_conv_busy();
      int end_cyc, dv_cyc, rows;
      @(negedge clk);
      conv_busy = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) begin
         @(negedge clk);
         n_vec++;
         if ({frame_busy, pix_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL busy_ignored got %b want 00", {frame_busy, pix_ready});
         end
      end
      conv_busy = 1'b0;
      repeat (3) begin
         @(negedge clk);
         n_vec++;
         if (frame_busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_not_queued got %b want 0", frame_busy);
         end
      end
      run_frame(0, 1'b0, 0, 1'b0, end_cyc, dv_cyc, rows);
      check_int("busy_later_rows", rows, ROWS);
      check_int("busy_later_length", end_cyc + 1, 1 + ROWS * (ROW_PIX + 1) + 1);
   endtask

   task automatic test_random();
      int end_cyc, dv_cyc, rows;
      repeat (3) begin
         run_frame(2, 1'b0, 0, 1'b0, end_cyc, dv_cyc, rows);
         check_int("rand_rows", rows, ROWS);
         @(negedge clk);
      end
   endtask

   task automatic test_abort();
      int end_cyc, dv_cyc, rows;
      run_frame(0, 1'b0, 6, 1'b0, end_cyc, dv_cyc, rows);
      check_int("abort_rows", rows, 6);
      check_int("abort_no_pool_end", end_cyc, -1);
      run_frame(0, 1'b0, 0, 1'b0, end_cyc, dv_cyc, rows);
      check_int("abort_clean_rows", rows, ROWS);
      check_int("abort_clean_length", end_cyc + 1, 1 + ROWS * (ROW_PIX + 1) + 1);
   endtask

   task automatic test_relu();
      int         end_cyc, dv_cyc, rows;
      row_t       r0;
      logic [7:0] want;
`ifdef CONV2_FEED_RELU_EN
      want = 8'h00;
`else
      want = 8'h85;
`endif
      run_frame(0, 1'b0, 0, 1'b1, end_cyc, dv_cyc, rows);
      n_vec++;
      if (obs_rows.size() == 0) begin
         n_err++;
         $display("FAIL relu_byte got no rows want one");
      end else begin
         r0 = obs_rows[0];
         if (r0[0][W-1 -: 8] !== want) begin
            n_err++;
            $display("FAIL relu_byte got %h want %h", r0[0][W-1 -: 8], want);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_throttled();
      test_conv_busy();
      test_random();
      test_abort();
      test_relu();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/conv2_row_feeder.md
CONV2_ROW_FEEDER -- requirements
Module: conv2_row_feeder

Interface
REQ-001 SHALL have parameter ROW_PIX, default 12, pixels per row (row word = 8*ROW_PIX bits).
REQ-002 SHALL have parameter ROWS, default 16, rows per frame; legal range 1..1023.
REQ-003 SHALL have port clk  in  1  clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  one-cycle pulse; begins a frame.
REQ-006 SHALL have port conv_busy  in  1  high while the downstream conv layer-2 replay is running.
REQ-007 SHALL have port pix_valid  in  1  the four pixel bytes are valid.
REQ-008 SHALL have port pix_ready  out  1  the feeder accepts the pixels this cycle.
REQ-009 SHALL have ports pix_0..pix_3  in  8 each  one pooled pixel per input channel.
REQ-010 SHALL have port din_valid  out  1  one-cycle row-write strobe to the conv layer-2 row buffer.
REQ-011 SHALL have ports data_in_0..data_in_3  out  8*ROW_PIX each  packed row per channel.
REQ-012 SHALL have port pool_end  out  1  one-cycle end-of-frame pulse.
REQ-013 SHALL have port frame_busy  out  1  high in every state except IDLE.

Function
REQ-014 SHALL implement the FSM IDLE -> FILL -> EMIT -> (FILL | END) -> IDLE.
REQ-015 IDLE: SHALL go to FILL on start=1 and conv_busy=0; start while conv_busy=1 SHALL be ignored, not queued.
REQ-016 FILL: SHALL drive pix_ready=1 and accept a pixel set on every cycle with pix_valid=1.
REQ-017 SHALL store pixel k of a row (k=0..ROW_PIX-1) at bits [8*ROW_PIX-1-8k -: 8], so pixel 0 lands in the MSB byte.
REQ-018 On acceptance of pixel ROW_PIX-1, SHALL go to EMIT; pix_ready SHALL be 0 in EMIT, END and IDLE.
REQ-019 EMIT: SHALL drive din_valid=1 for exactly one cycle with all four completed rows stable on data_in_0..3.
REQ-020 SHALL hold data_in_0..3 stable until the next din_valid and SHALL clear the pixel counter after EMIT.
REQ-021 After EMIT: SHALL go to END when the row counter equals ROWS-1, otherwise to FILL with the row counter incremented.
REQ-022 END: SHALL drive pool_end=1 for exactly one cycle, clear the row counter, and return to IDLE.
REQ-023 din_valid and pool_end SHALL never be high in the same cycle.
REQ-024 The minimum frame length from start to pool_end SHALL be 1 + ROWS*(ROW_PIX+1) + 1 cycles when pix_valid is held high.
REQ-025 Gaps in pix_valid SHALL stall FILL with no loss or duplication of pixels; counters SHALL NOT wrap within a frame.
REQ-026 start pulses outside IDLE SHALL be ignored.
REQ-027 conv_busy SHALL be sampled only in IDLE.

Reset
REQ-028 On rst_n=0, SHALL immediately force state=IDLE, both counters=0, data_in_0..3=0, and din_valid, pool_end, pix_ready and frame_busy=0.
REQ-029 Reset asserted mid-frame SHALL abandon the partial frame without issuing pool_end; after release, the block SHALL wait for a new start.

Configuration
REQ-030 With macro CONV2_FEED_RELU_EN defined, any accepted pixel with bit 7 set SHALL be stored as 8'h00 (signed ReLU clamp).
REQ-031 Without CONV2_FEED_RELU_EN, pixels SHALL be stored unmodified; all timing SHALL be identical in both builds.

Verification
REQ-032 Defaults, start, 12 pixels with pix_0=k (k=0..11) -> din_valid one cycle later; data_in_0=96'h000102030405060708090A0B.
REQ-033 Full frame with pix_valid held high -> 16 din_valid pulses, then one pool_end; start-to-pool_end = 210 cycles.
REQ-034 pix_valid toggled 1/0 each cycle -> row contents identical to the unthrottled run; 16 rows; pool_end produced.
REQ-035 start with conv_busy=1 -> stays in IDLE, frame_busy=0; a later start with conv_busy=0 -> frame begins.
REQ-036 rst_n pulsed low after row 5 -> all outputs 0 at once; no pool_end; a new start yields a clean 16-row frame.
REQ-037 Pixel 8'h85 with CONV2_FEED_RELU_EN defined -> stored as 8'h00; without the macro -> stored as 8'h85.
